pipe_fifo: RTL and testbench
============================

# pipe_fifo

Synchronous valid/ready FIFO that decouples two pipeline stages within one clock domain. A producer pushes `DW`-bit words on the input handshake, and a consumer pops them in order on the output handshake. Storage is built from the team's no-reset load-enable flops (`dff_l`). Pointers and flags use reset-to-0 load-enable flops (`dff_lr`). Both handshake outputs are driven only by flops, so the block also serves as a timing cut between stages.

## Interface
Parameters:
- `DW`, 32: data width in bits, ≥1.
- `DP`, 4: depth in entries, ≥1, any integer (power of 2 not required).

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low. One clock domain only.
- `i_vld` in 1: producer has a word.
- `i_rdy` out 1: FIFO can accept a word.
- `i_dat` in DW: producer word.
- `o_vld` out 1: FIFO holds a word.
- `o_rdy` in 1: consumer accepts a word.
- `o_dat` out DW: head word.
- `cnt` out CW: number of stored entries, where CW = $clog2(DP+1).

## Operation
- Push occurs when `i_vld & i_rdy`: `i_dat` is written at `wr_ptr`, then `wr_ptr` advances.
- Pop occurs when `o_vld & o_rdy`: `rd_ptr` advances.
- Pointer width is AW = (DP>1) ? $clog2(DP) : 1, plus one wrap flag per pointer.
- Pointer advance: if ptr == DP-1, the pointer goes to 0 and the wrap flag toggles; otherwise the pointer increments by 1.
- empty = (rd_ptr == wr_ptr) & (rd_wrap == wr_wrap).
- full = (rd_ptr == wr_ptr) & (rd_wrap != wr_wrap).
- `i_rdy` = ~full. `o_vld` = ~empty.
- `o_dat` = mem[rd_ptr]. It is a combinational read of registered storage, with no bypass from `i_dat`.
- `cnt` is a registered counter:
  - +1 on a push-only cycle.
  - −1 on a pop-only cycle.
  - Unchanged when push and pop both occur, or when neither occurs.
  - `cnt` never exceeds DP and never underflows below 0.
- Boundary conditions:
  - **Full, `i_vld=1`, pop this cycle:** the push is not accepted because `i_rdy`=0. `i_rdy` rises next cycle.
  - **Empty, `o_rdy=1`, push this cycle:** no pop occurs. `o_vld` rises next cycle.
  - **Simultaneous push and pop, neither full nor empty:** both occur and `cnt` is held.
  - **Wrap-around:** both pointers wrap independently, and order is preserved across the wrap.
  - **DP=1:** the block behaves as a half-rate single register stage, alternating full and empty.
- The producer must hold `i_vld` and `i_dat` stable while `i_rdy`=0. Violating this is a protocol error and is not detected.
- The block has no combinational path from `i_vld` to `o_vld`, or from `o_rdy` to `i_rdy`.

## Timing
- Reset (`rst_n`=0, asynchronous):
  - `rd_ptr`, `wr_ptr`, both wrap flags and `cnt` go to 0.
  - Resulting outputs: `o_vld`=0, `i_rdy`=1, `cnt`=0.
  - Memory contents are not reset, so `o_dat` is undefined while `o_vld`=0.
- Reset mid-operation: all stored entries are discarded immediately. No pop is seen after reset until a new push occurs.
- The first active edge after reset deassertion is a normal cycle.
- Latency: a word pushed at edge n is visible on `o_dat` with `o_vld`=1 after edge n, and can be popped at edge n+1.
- Throughput is 1 word/cycle in steady state when 0 < cnt < DP. For DP=1 it is 1 word per 2 cycles.
- All outputs except `o_dat` are flop outputs. `o_dat` is a mux of flop outputs selected by `rd_ptr`.

## Test plan
1. **Reset.** Assert `rst_n`=0 mid-cycle with `i_vld`=1 → outputs are immediately `o_vld`=0, `i_rdy`=1, `cnt`=0. Release reset and push 0xA5A5A5A5 → `o_vld`=1 one cycle later and `o_dat`=0xA5A5A5A5.
2. **Fill and drain (DP=4).** Push 0x1, 0x2, 0x3, 0x4 with `o_rdy`=0 → `cnt`=4 and `i_rdy`=0. A 5th `i_vld` is held with 0x5 and is not accepted. Then set `o_rdy`=1 → pops 1, 2, 3, 4 in order, then 0x5 is accepted on the first cycle after a pop.
3. **Full plus pop.** At `cnt`=4, set `i_vld`=1 and `o_rdy`=1 → one pop and no push that cycle, so `cnt`=3. Next cycle the push and pop both occur and `cnt` stays 3.
4. **Empty plus push.** At `cnt`=0, set `i_vld`=1 and `o_rdy`=1 → no pop that cycle and `cnt`=1. After that, push and pop together at 1 word/cycle for 20 cycles → `cnt` stays 1 and the outputs are in order.
5. **Wrap and non-power-of-2 depth (DP=3).** Stream 0..99 with random `i_vld` and `o_rdy` → output sequence is exactly 0..99 and `cnt` stays in 0..3. A scoreboard checks `cnt` against the push/pop count every cycle.
6. **DP=1.** Continuous `i_vld`=1 and `o_rdy`=1 → `i_rdy` and `o_vld` alternate each cycle, and words arrive in order at half rate.

Source files
------------

// File: rtl/pipe_fifo.sv
// pipe_fifo: synchronous valid/ready FIFO acting as a timing cut between two
// pipeline stages. Storage words have no reset; pointers, wrap flags and the
// occupancy counter reset to zero. Depth need not be a power of two.
module pipe_fifo #(
  parameter int DW = 32,
  parameter int DP = 4,
  localparam int CW = $clog2(DP + 1),
  localparam int AW = (DP > 1) ? $clog2(DP) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_vld,
  output logic          i_rdy,
  input  logic [DW-1:0] i_dat,
  output logic          o_vld,
  input  logic          o_rdy,
  output logic [DW-1:0] o_dat,
  output logic [CW-1:0] cnt
);

  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          rd_wrap;
  logic          wr_wrap;
  logic [DW-1:0] mem [DP];

  logic          push;
  logic          pop;
  logic          ptr_eq;
  logic          empty;
  logic          full;
  logic [AW:0]   wr_nxt;
  logic [AW:0]   rd_nxt;

  // Advance a pointer by one entry, toggling its wrap flag when it passes the
  // last slot. Returns {wrap, ptr}.
  function automatic logic [AW:0] ptr_adv(input logic [AW-1:0] ptr,
                                          input logic          wrap);
    if (ptr == AW'(DP - 1)) begin
      return {~wrap, AW'(0)};
    end
    return {wrap, ptr + AW'(1)};
  endfunction

  // Flags depend only on registered pointers, so neither handshake output has
  // a combinational path from the opposite handshake input.
  assign ptr_eq = (rd_ptr == wr_ptr);
  assign empty  = ptr_eq & (rd_wrap == wr_wrap);
  assign full   = ptr_eq & (rd_wrap != wr_wrap);
  assign i_rdy  = ~full;
  assign o_vld  = ~empty;
  assign push   = i_vld & i_rdy;
  assign pop    = o_vld & o_rdy;
  assign wr_nxt = ptr_adv(wr_ptr, wr_wrap);
  assign rd_nxt = ptr_adv(rd_ptr, rd_wrap);

  // Head word: plain read of storage, never bypassed from i_dat.
  assign o_dat = mem[rd_ptr];

  // Storage write on an accepted push.
  // NOTE: the data array has no reset; o_vld already qualifies its contents,
  // and leaving it out keeps the reset net off every storage bit.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= i_dat;
    end
  end

  // Write pointer and wrap flag, loaded on push.
  // NOTE: all state updates use non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      wr_wrap <= 1'b0;
    end else if (push) begin
      wr_wrap <= wr_nxt[AW];
      wr_ptr  <= wr_nxt[AW-1:0];
    end
  end

  // Read pointer and wrap flag, loaded on pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr  <= '0;
      rd_wrap <= 1'b0;
    end else if (pop) begin
      rd_wrap <= rd_nxt[AW];
      rd_ptr  <= rd_nxt[AW-1:0];
    end
  end

  // Occupancy counter: push-only increments, pop-only decrements. Bounds hold
  // because push is blocked when full and pop is blocked when empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_fifo.sv
// tb_pipe_fifo: three pipe_fifo instances (DP=4, DP=3, DP=1) checked every
// cycle against a queue-level model (a log of pushed words plus push/pop
// totals), with directed vectors carrying literal expectations.
module tb_pipe_fifo;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  i_vld = '0;
  logic [2:0]  o_rdy = '0;
  logic [2:0]  i_rdy;
  logic [2:0]  o_vld;
  logic [31:0] i_dat [3];
  logic [31:0] o_dat [3];
  logic [2:0]  cnt0;
  logic [1:0]  cnt1;
  logic [0:0]  cnt2;

  int n_vec = 0;
  int n_bad = 0;

  // Model state: every accepted word is logged; occupancy is pushes - pops.
  int          push_n [3] = '{0, 0, 0};
  int          pop_n  [3] = '{0, 0, 0};
  logic [31:0] log_m  [3][1024];

  always #5 clk = ~clk;

  pipe_fifo #(.DW(32), .DP(4)) u_dp4 (
    .clk(clk), .rst_n(rst_n), .i_vld(i_vld[0]), .i_rdy(i_rdy[0]), .i_dat(i_dat[0]),
    .o_vld(o_vld[0]), .o_rdy(o_rdy[0]), .o_dat(o_dat[0]), .cnt(cnt0));
  pipe_fifo #(.DW(32), .DP(3)) u_dp3 (
    .clk(clk), .rst_n(rst_n), .i_vld(i_vld[1]), .i_rdy(i_rdy[1]), .i_dat(i_dat[1]),
    .o_vld(o_vld[1]), .o_rdy(o_rdy[1]), .o_dat(o_dat[1]), .cnt(cnt1));
  pipe_fifo #(.DW(32), .DP(1)) u_dp1 (
    .clk(clk), .rst_n(rst_n), .i_vld(i_vld[2]), .i_rdy(i_rdy[2]), .i_dat(i_dat[2]),
    .o_vld(o_vld[2]), .o_rdy(o_rdy[2]), .o_dat(o_dat[2]), .cnt(cnt2));

  function automatic int dp_of(input int k);
    case (k)
      0:       return 4;
      1:       return 3;
      default: return 1;
    endcase
  endfunction

  function automatic int cnt_of(input int k);
    case (k)
      0:       return int'(cnt0);
      1:       return int'(cnt1);
      default: return int'(cnt2);
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Model update: a push is accepted while occupancy < DP, a pop while
  // occupancy > 0; reset discards everything currently held.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) pop_n[k] <= push_n[k];
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (i_vld[k] && (push_n[k] - pop_n[k] < dp_of(k))) begin
          log_m[k][push_n[k] % 1024] <= i_dat[k];
          push_n[k] <= push_n[k] + 1;
        end
        if (o_rdy[k] && (push_n[k] != pop_n[k])) pop_n[k] <= pop_n[k] + 1;
      end
    end
  end

  // Per-cycle comparison of every instance against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 3; k++) begin
        check($sformatf("mdl%0d_cnt", k), 32'(cnt_of(k)), 32'(push_n[k] - pop_n[k]));
        check($sformatf("mdl%0d_o_vld", k), 32'(o_vld[k]), 32'(push_n[k] != pop_n[k]));
        check($sformatf("mdl%0d_i_rdy", k), 32'(i_rdy[k]),
              32'((push_n[k] - pop_n[k]) < dp_of(k)));
        if (push_n[k] != pop_n[k])
          check($sformatf("mdl%0d_o_dat", k), o_dat[k], log_m[k][pop_n[k] % 1024]);
      end
    end
  end

  initial begin
    int nv;
    int exp_out;
    logic acc_prev;
    logic acc;

    for (int k = 0; k < 3; k++) i_dat[k] = '0;

    // Reset, including an asynchronous assertion mid-cycle while pushing.
    cyc();
    cyc();
    rst_n = 1'b1;
    check("rst_o_vld", 32'(o_vld[0]), 32'd0);
    check("rst_i_rdy", 32'(i_rdy[0]), 32'd1);
    i_vld[0] = 1'b1; i_dat[0] = 32'h11;
    cyc();
    i_dat[0] = 32'h22;
    cyc();
    check("pre_rst_cnt", 32'(cnt0), 32'd2);
    i_dat[0] = 32'hA5A5A5A5;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_o_vld", 32'(o_vld[0]), 32'd0);
    check("midrst_i_rdy", 32'(i_rdy[0]), 32'd1);
    check("midrst_cnt", 32'(cnt0), 32'd0);
    cyc();
    rst_n = 1'b1;
    cyc();
    i_vld[0] = 1'b0;
    check("a5_o_vld", 32'(o_vld[0]), 32'd1);
    check("a5_o_dat", o_dat[0], 32'hA5A5A5A5);
    o_rdy[0] = 1'b1;
    cyc();
    o_rdy[0] = 1'b0;
    check("a5_drained", 32'(o_vld[0]), 32'd0);

    // Fill DP=4, hold a fifth word against a full FIFO, then drain.
    for (int v = 1; v <= 4; v++) begin
      i_vld[0] = 1'b1; i_dat[0] = 32'(v);
      cyc();
    end
    check("full_cnt", 32'(cnt0), 32'd4);
    check("full_i_rdy", 32'(i_rdy[0]), 32'd0);
    i_dat[0] = 32'h5;
    cyc();
    cyc();
    check("held_cnt", 32'(cnt0), 32'd4);
    check("held_head", o_dat[0], 32'h1);
    o_rdy[0] = 1'b1;
    cyc();
    check("fullpop_cnt", 32'(cnt0), 32'd3);
    check("fullpop_i_rdy", 32'(i_rdy[0]), 32'd1);
    check("drain_2", o_dat[0], 32'h2);
    cyc();
    i_vld[0] = 1'b0;
    check("both_cnt", 32'(cnt0), 32'd3);
    check("drain_3", o_dat[0], 32'h3);
    cyc();
    check("drain_4", o_dat[0], 32'h4);
    cyc();
    check("drain_5", o_dat[0], 32'h5);
    cyc();
    check("drained_o_vld", 32'(o_vld[0]), 32'd0);
    check("drained_cnt", 32'(cnt0), 32'd0);

    // Empty plus push, then 20 cycles of simultaneous push and pop.
    i_vld[0] = 1'b1; i_dat[0] = 32'd100;
    cyc();
    check("emptypush_cnt", 32'(cnt0), 32'd1);
    for (int i = 0; i < 20; i++) begin
      check("stream_cnt", 32'(cnt0), 32'd1);
      check("stream_dat", o_dat[0], 32'(100 + i));
      i_dat[0] = 32'(101 + i);
      cyc();
    end
    i_vld[0] = 1'b0;
    check("stream_last", o_dat[0], 32'd120);
    cyc();
    o_rdy[0] = 1'b0;
    check("stream_done", 32'(o_vld[0]), 32'd0);

    // DP=3: stream 0..99 with random handshakes; order and occupancy tracked
    // locally from the handshakes that were offered.
    nv = 0; exp_out = 0; acc_prev = 1'b0;
    for (int c = 0; c < 3000 && exp_out < 100; c++) begin
      check("dp3_cnt_sb", 32'(cnt1), 32'(nv - exp_out));
      if (!(i_vld[1] && !acc_prev)) begin
        i_vld[1] = (nv < 100) && ($urandom_range(0, 1) == 1);
        i_dat[1] = 32'(nv);
      end
      o_rdy[1] = ($urandom_range(0, 1) == 1);
      acc = i_vld[1] & i_rdy[1];
      if (o_vld[1] && o_rdy[1]) begin
        check("dp3_order", o_dat[1], 32'(exp_out));
        exp_out++;
      end
      if (acc) nv++;
      acc_prev = acc;
      cyc();
    end
    i_vld[1] = 1'b0; o_rdy[1] = 1'b0;
    check("dp3_all_out", 32'(exp_out), 32'd100);

    // DP=1: alternating full/empty at half rate.
    for (int k = 0; k < 12; k++) begin
      check("dp1_i_rdy", 32'(i_rdy[2]), 32'(k % 2 == 0));
      check("dp1_o_vld", 32'(o_vld[2]), 32'(k % 2 == 1));
      if (k % 2 == 1) check("dp1_o_dat", o_dat[2], 32'(16 + (k - 1) / 2));
      else i_dat[2] = 32'(16 + k / 2);
      i_vld[2] = 1'b1; o_rdy[2] = 1'b1;
      cyc();
    end
    i_vld[2] = 1'b0; o_rdy[2] = 1'b0;
    cyc();
    check("dp1_end", 32'(o_vld[2]), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
